// File: rtl/bus_ep_pkg.sv
// bus_ep_pkg: shared destination-field helpers and saturating counter type for bus_endpoint
package bus_ep_pkg;
    localparam int DEST_W = 8;

    typedef logic [7:0] sat8_t;

    function automatic logic [DEST_W-1:0] dest_of(input logic [63:0] pkt, input int w);
        return pkt[w-1 -: DEST_W];
    endfunction

    function automatic logic accept(input logic [DEST_W-1:0] dest, input logic [DEST_W-1:0] id,
                                    input logic [DEST_W-1:0] bcast);
        return dest == id || dest == bcast;
    endfunction

    function automatic sat8_t sat_inc(input sat8_t c);
        return c == 8'hFF ? c : c + 8'd1;
    endfunction
endpackage

// File: rtl/ep_fifo.sv
// ep_fifo: show-ahead synchronous FIFO; full/empty derive from a registered occupancy count
module ep_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [width-1:0]         wdata,
    input  logic                     rd,
    output logic [width-1:0]         rdata,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    logic [width-1:0] mem [depth];
    logic [AW-1:0] wp, rp;
    logic do_wr, do_rd;
    assign full  = count == CW'(depth);
    assign empty = count == '0;
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign rdata = mem[rp];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (do_rd) rp <= rp + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/bus_endpoint.sv
// bus_endpoint: device-side bus endpoint with TX/RX FIFOs, destination filtering,
// saturating drop/misroute statistics and a sticky pop-underflow flag
module bus_endpoint
    import bus_ep_pkg::*;
#(
    parameter int                pckg_sz   = 16,
    parameter int                depth     = 8,
    parameter logic [DEST_W-1:0] dev_id    = 8'd0,
    parameter logic [DEST_W-1:0] broadcast = 8'b0000_0111
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_valid,
    input  logic [pckg_sz-1:0]     tx_data,
    output logic                   tx_ready,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    output logic                   rx_valid,
    output logic [pckg_sz-1:0]     rx_data,
    input  logic                   rx_ready,
    output logic [$clog2(depth):0] tx_count,
    output logic [$clog2(depth):0] rx_count,
    output logic [7:0]             drop_cnt,
    output logic [7:0]             misroute_cnt,
    output logic                   underflow
);
    logic tx_full, tx_empty, rx_full, rx_empty, hit;
    assign tx_ready = !tx_full;
    assign pndng    = !tx_empty;
    assign rx_valid = !rx_empty;
    assign hit      = accept(dest_of(64'(D_push), pckg_sz), dev_id, broadcast);

    ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk, .reset, .wr(tx_valid), .wdata(tx_data), .rd(pop), .rdata(D_pop),
        .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk, .reset, .wr(push && hit), .wdata(D_push), .rd(rx_ready), .rdata(rx_data),
        .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // rx_full is registered, so a same-cycle host read never frees room for a push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt     <= '0;
            misroute_cnt <= '0;
            underflow    <= 1'b0;
        end else begin
            if (push && !hit) misroute_cnt <= sat_inc(misroute_cnt);
            if (push && hit && rx_full) drop_cnt <= sat_inc(drop_cnt);
            if (pop && !pndng) underflow <= 1'b1;
        end
    end
endmodule

// File: doc/bus_endpoint.md
# bus_endpoint

Device-side endpoint for the shared-bus generator/arbiter (`bs_gnrtr_n_rbtr`). It is the synthesizable counterpart of one bus driver. It exposes a transmit FIFO on the arbiter's `pndng`/`pop`/`D_pop` side and accepts arbiter deliveries on `push`/`D_push` into a receive FIFO. Both FIFOs have a simple valid/ready host interface. One instance sits on each of the `drvrs` ports of the bus; the `bits` dimension is handled by instantiating one endpoint per bus/device pair.

## Interface
- `pckg_sz`, 16: packet width in bits; destination ID is `[pckg_sz-1:pckg_sz-8]`.
- `depth`, 8: entries per FIFO; power of two, minimum 2.
- `dev_id`, 0: 8-bit ID of this endpoint.
- `broadcast`, 8'b0000_0111: destination ID accepted by every endpoint.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `tx_valid`, in, 1: host offers a packet for transmission.
- `tx_data`, in, `pckg_sz`: packet to transmit.
- `tx_ready`, out, 1: TX FIFO not full.
- `pndng`, out, 1: TX FIFO non-empty; goes to the arbiter.
- `D_pop`, out, `pckg_sz`: head of the TX FIFO (show-ahead).
- `pop`, in, 1: arbiter consumes the head.
- `push`, in, 1: arbiter delivers a packet.
- `D_push`, in, `pckg_sz`: delivered packet.
- `rx_valid`, out, 1: RX FIFO non-empty.
- `rx_data`, out, `pckg_sz`: head of the RX FIFO (show-ahead).
- `rx_ready`, in, 1: host consumes the RX head.
- `tx_count`, out, `$clog2(depth)+1`: TX occupancy.
- `rx_count`, out, `$clog2(depth)+1`: RX occupancy.
- `drop_cnt`, out, 8: RX overflow drops, saturating at 255.
- `misroute_cnt`, out, 8: rejected deliveries, saturating at 255.
- `underflow`, out, 1: sticky flag; `pop` was seen while `pndng`=0.

## Operation
- **TX write:** occurs when `tx_valid && tx_ready`; data goes to the tail.
- **TX pop:** occurs when `pop && pndng`; the head advances.
- **Pop while empty:** no state change other than setting `underflow`.
- **RX acceptance:** `push` is accepted only when dest == `dev_id` or dest == `broadcast`.
  - If accepted and RX is not full, the packet is written to the tail.
  - If accepted and RX is full, the packet is dropped and `drop_cnt`++.
- **Misroute:** a `push` with any other dest is discarded and `misroute_cnt`++. It never occupies RX.
- **RX read:** occurs when `rx_valid && rx_ready`; the head advances.
- **Pointers:** `$clog2(depth)` bits each and wrap modulo `depth`. Occupancy is tracked in a separate counter, so full and empty are never ambiguous.
- **Counters:** saturate and never wrap. Only reset clears them.
- **Reset (`reset`=0):**
  - Pointers, counts, `drop_cnt`, `misroute_cnt` and `underflow` clear to 0.
  - `pndng`=0, `rx_valid`=0, `tx_ready`=1.
  - `D_pop`/`rx_data` read 0, because storage is cleared.
  - Reset mid-transfer discards all contents. The first valid edge after release behaves as from empty.

## Timing
- **TX path latency:** write at edge N, so `pndng`=1 and `D_pop`=data after edge N. The arbiter can pop at edge N+1.
- **TX pop:** pop at edge N presents the next head (or `pndng`=0) after edge N. Back-to-back pops every cycle are supported.
- **RX path latency:** push at edge N, so `rx_valid`=1 after edge N if RX was empty.
- **Full/empty flags come from registered occupancy.**
  - `tx_ready`=0 at `tx_count`==`depth`, even if `pop` is high in the same cycle. There is no full-pass-through.
  - RX full with `rx_ready` high in the same cycle as `push`: the push is still dropped, because the full flag is registered. Checkers model it exactly this way.
- **Simultaneous write and pop/read (non-full, non-empty):** the count is unchanged and both pointers advance.
- **Write into an empty FIFO with pop in the same cycle:** the pop is ignored (underflow set) and the write lands.

## Structure
- **Package `bus_ep_pkg`:**
  - `localparam DEST_W = 8`.
  - Function `dest_of(pkt)` that extracts the top 8 bits.
  - Function `accept(dest, id, bcast)`.
  - Typedef for the saturating 8-bit counter.
- **Sub-module `ep_fifo`:** a show-ahead synchronous FIFO with parameters `width` and `depth`, and ports `wr`, `wdata`, `rd`, `rdata`, `count`, `full`, `empty`. It is instantiated twice. The top level holds address filtering, counters and the sticky flag.

## Test plan
- **TX basic:** with `dev_id`=1, write 0x02AB, then 0x03CD.
  - `pndng`=1 after the first edge.
  - `D_pop`=0x02AB, then 0x03CD after one pop.
  - `pndng`=0 after the second pop.
  - `tx_count` reads 1, 2, 1, 0.
- **TX full:** write 8 packets, then hold `tx_valid` with `pop`=1.
  - `tx_ready`=0 in that cycle, and the 9th packet is not written.
  - Order 0..7 is preserved across pointer wrap.
- **RX filter:** push 0x01AA, 0x0755 and 0x04FF to `dev_id`=1.
  - RX holds 0x01AA then 0x0755.
  - `misroute_cnt`=1 and `rx_count`=2.
- **RX overflow:** with `rx_ready`=0, push 10 packets to ID 1.
  - `rx_count`=8 and `drop_cnt`=2.
  - Pushing a 9th packet with `rx_ready`=1 in the same cycle is still dropped (`drop_cnt`=3).
- **Underflow:** pop with TX empty.
  - `underflow`=1 and it stays 1.
  - A subsequent write behaves normally.
- **Reset mid-operation:** with TX=3 and RX=2 entries, pulse `reset` low asynchronously between edges.
  - All counts, flags and counters read 0 immediately.
  - `tx_ready`=1.
  - A post-reset write appears at `D_pop` after one edge.
